msk_skinny_job_sched: RTL
=========================

// Module: msk_skinny_job_sched
// PURPOSE
//  Shares one masked SKINNY core (with its Borrowed-Time FSM) between NREQ requesters.
//  - Arbitrates round-robin and latches the winner's shared plaintext/key.
//  - Pulses the core start, supervises the run with a watchdog, and returns the ciphertext with the requester ID.
//  - On a Borrowed-Time alarm or timeout, it aborts the job, drives the core clear and returns an abort response.
//  - Sits between the requester bus and the masked SKINNY FSM top level.
// PARAMETERS
//  D          2    masking order; every data bus is 128*D bits of shares
//  NREQ       4    number of requesters (2..8)
//  TIMEOUT    250  max RUN cycles before abort (core nominal 240 = 40 rounds x 6 cycles)
//  CLR_CYCLES 2    cycles core_clear is held during a flush
// PORTS
//  clk        in   1            clock
//  reset      in   1            synchronous, active-high
//  req_valid  in   NREQ         requester i has a job
//  req_pt     in   NREQ*128*D   requester plaintext shares; slice i = [i*128*D +: 128*D]
//  req_key    in   NREQ*128*D   requester key shares, same slicing
//  req_ready  out  NREQ         one-hot accept pulse
//  rng_ok     in   1            PRNG has fresh rnd/rnd_BT available
//  alarm      in   1            Borrowed-Time supply alarm
//  core_start out  1            one-cycle start to the core
//  core_pt    out  128*D        latched plaintext shares
//  core_key   out  128*D        latched key shares
//  core_clear out  1            clear to the core (BT flush)
//  core_done  in   1            core completion pulse
//  core_ct    in   128*D        core ciphertext shares, valid with core_done
//  rsp_valid  out  1            response available
//  rsp_ready  in   1            consumer accepts the response
//  rsp_id     out  $clog2(NREQ) requester that owns the response
//  rsp_ct     out  128*D        ciphertext shares; zero when aborted
//  rsp_abort  out  1            job aborted (alarm or timeout)
// BEHAVIOUR
//  Reset
//  - state=IDLE; all outputs 0; hold registers (pt/key/ct) zeroed.
//  - rr_ptr=NREQ-1, so requester 0 has the highest priority first.
//  - Reset mid-job drops the job silently: no response, no core_clear.
//  IDLE
//  - core_clear=alarm.
//  - Grant when alarm=0, rng_ok=1 and |req_valid: g = first set bit scanning from rr_ptr+1, wrapping.
//  - On grant: req_ready[g]=1 for that cycle; latch pt/key/id; rr_ptr<=g; go START.
//  START
//  - core_start=1 for exactly one cycle; timer<=0; go RUN.
//  - If alarm=1: no start; go FLUSH.
//  RUN
//  - timer increments each cycle.
//  - Priority order: alarm, then timer==TIMEOUT-1, then core_done.
//  - alarm -> FLUSH. timeout -> FLUSH.
//  - core_done -> latch core_ct into rsp_ct, rsp_abort=0, go RESP.
//  - alarm and core_done in the same cycle: abort wins; CT is discarded.
//  FLUSH
//  - core_clear=1 for CLR_CYCLES cycles.
//  - pt/key/ct hold registers zeroed on entry.
//  - Then rsp_abort=1, rsp_ct=0, go RESP.
//  RESP
//  - rsp_valid=1; rsp_id, rsp_ct, rsp_abort held stable until rsp_valid&rsp_ready, then IDLE.
//  - An alarm arriving while rsp_abort=0: rsp_ct<=0, rsp_abort<=1 next cycle; stay in RESP.
//  - No new grant while RESP is occupied; at most one job is in flight.
//  Other rules
//  - Latency: grant to core_start = 1 cycle; core_done to rsp_valid = 1 cycle.
//  - A requester dropping req_valid before its grant is not an error.
//  - core_pt/core_key are stable from START until the state leaves RUN.
// TESTING
//  - Single job: req_valid=4'b0010, pt=0x06034F95..., core_done after 240 cycles -> rsp_id=1, rsp_ct=core_ct, abort=0.
//  - Fairness: all 4 requesters held valid for 8 jobs -> grant order 0,1,2,3,0,1,2,3.
//  - Alarm at RUN cycle 100 -> core_clear high for 2 cycles, then rsp_abort=1, rsp_ct=0.
//  - Alarm coincident with core_done -> abort response, CT discarded.
//  - core_done never arrives -> abort after exactly 250 RUN cycles.
//  - rng_ok=0 with req_valid set -> no grant; rng_ok rising -> req_ready the same cycle.
//  - rsp_ready held low for 20 cycles -> response stable; no new core_start meanwhile.

Source files
------------

// File: rtl/msk_skinny_job_sched.sv
// Job scheduler for one shared masked SKINNY core.
// Round-robin arbitration across NREQ requesters, one job in flight at a time.
// A watchdog and the Borrowed-Time alarm can abort a job; a flush pulses
// core_clear before an abort response is returned.
module msk_skinny_job_sched #(
    parameter int D          = 2,
    parameter int NREQ       = 4,
    parameter int TIMEOUT    = 250,
    parameter int CLR_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*128*D-1:0]     req_pt,
    input  logic [NREQ*128*D-1:0]     req_key,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      rng_ok,
    input  logic                      alarm,
    output logic                      core_start,
    output logic [128*D-1:0]          core_pt,
    output logic [128*D-1:0]          core_key,
    output logic                      core_clear,
    input  logic                      core_done,
    input  logic [128*D-1:0]          core_ct,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [128*D-1:0]          rsp_ct,
    output logic                      rsp_abort
);

    localparam int W    = 128 * D;
    localparam int IDW  = $clog2(NREQ);
    localparam int NPOW = 1 << IDW;
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam int CW   = $clog2(CLR_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t           state_reg;
    logic [IDW-1:0]   rr_ptr_reg;
    logic [IDW-1:0]   id_reg;
    logic [W-1:0]     pt_reg;
    logic [W-1:0]     key_reg;
    logic [W-1:0]     ct_reg;
    logic             abort_reg;
    logic [TW-1:0]    timer_reg;
    logic [CW-1:0]    flush_cnt_reg;

    // Per-requester share slices, padded to a power of two so any grant
    // index is a legal array index.
    logic [W-1:0]     pt_arr  [NPOW];
    logic [W-1:0]     key_arr [NPOW];

    genvar gi;
    generate
        for (gi = 0; gi < NPOW; gi++) begin : g_slice
            if (gi < NREQ) begin : g_real
                assign pt_arr[gi]  = req_pt[gi*W +: W];
                assign key_arr[gi] = req_key[gi*W +: W];
            end else begin : g_pad
                assign pt_arr[gi]  = '0;
                assign key_arr[gi] = '0;
            end
        end
    endgenerate

    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic             grant_fire;

    // Round-robin search: first valid requester after rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!grant_found && req_valid[(int'(rr_ptr_reg) + k) % NREQ]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'((int'(rr_ptr_reg) + k) % NREQ);
            end
        end
    end

    assign grant_fire = (state_reg == IDLE) && !alarm && rng_ok && grant_found;

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = grant_fire && (grant_idx == IDW'(gi));
        end
    endgenerate

    // The start pulse is suppressed if the alarm shows up in the START cycle.
    assign core_start = (state_reg == START) && !alarm;
    assign core_clear = (state_reg == FLUSH) || ((state_reg == IDLE) && alarm);
    assign core_pt    = pt_reg;
    assign core_key   = key_reg;
    assign rsp_valid  = (state_reg == RESP);
    assign rsp_id     = id_reg;
    assign rsp_ct     = ct_reg;
    assign rsp_abort  = abort_reg;

    // Scheduler FSM: grant, start, supervise, flush and respond.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= IDW'(NREQ - 1);
            id_reg        <= '0;
            pt_reg        <= '0;
            key_reg       <= '0;
            ct_reg        <= '0;
            abort_reg     <= 1'b0;
            timer_reg     <= '0;
            flush_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_fire) begin
                        pt_reg     <= pt_arr[grant_idx];
                        key_reg    <= key_arr[grant_idx];
                        id_reg     <= grant_idx;
                        rr_ptr_reg <= grant_idx;
                        abort_reg  <= 1'b0;
                        state_reg  <= START;
                    end
                end
                START: begin
                    timer_reg <= '0;
                    if (alarm) begin
                        pt_reg        <= '0;
                        key_reg       <= '0;
                        ct_reg        <= '0;
                        flush_cnt_reg <= '0;
                        state_reg     <= FLUSH;
                    end else begin
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    timer_reg <= timer_reg + TW'(1);
                    // Abort beats completion: a CT produced under alarm is untrusted.
                    if (alarm || (timer_reg == TW'(TIMEOUT - 1))) begin
                        pt_reg        <= '0;
                        key_reg       <= '0;
                        ct_reg        <= '0;
                        flush_cnt_reg <= '0;
                        state_reg     <= FLUSH;
                    end else if (core_done) begin
                        ct_reg    <= core_ct;
                        abort_reg <= 1'b0;
                        state_reg <= RESP;
                    end
                end
                FLUSH: begin
                    if (flush_cnt_reg == CW'(CLR_CYCLES - 1)) begin
                        abort_reg <= 1'b1;
                        ct_reg    <= '0;
                        state_reg <= RESP;
                    end else begin
                        flush_cnt_reg <= flush_cnt_reg + CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        abort_reg <= 1'b0;
                        state_reg <= IDLE;
                    end else if (alarm && !abort_reg) begin
                        // A late alarm poisons a pending good result.
                        ct_reg    <= '0;
                        abort_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
